alu_seq: RTL and testbench

- Parametrised, sequential successor to the combinational `alu`.
- Adds valid/ready handshakes, registered results, and a status-flag output.
- Adds multi-bit shifts executed one bit per cycle, plus a logical shift right and a shift-add multiply.
- Sits between the operand/decode stage and writeback; accepts one operation at a time.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu.sv | 58 +++++
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_pkg                                                |
// | Description : Shared operation, flag and state types for the ALU.    |
// | Revision    : 1.0 - initial sequential ALU release                   |
// +----------------------------------------------------------------------+
package alu_pkg;

  // Operation encodings: the first eight match the original combinational
  // alu, LSR and MUL are new. Encodings 10..15 are unused.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_OR  = 4'd1,
    ALU_AND = 4'd2,
    ALU_XOR = 4'd3,
    ALU_NOT = 4'd4,
    ALU_NEG = 4'd5,
    ALU_ASR = 4'd6,
    ALU_LSL = 4'd7,
    ALU_LSR = 4'd8,
    ALU_MUL = 4'd9
  } alu_operation_e;

  // Status flags, z in the MSB down to v in the LSB.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_seq_state_e;

  // Shifts iterate one bit per cycle in the sequencer.
  function automatic logic is_shift(alu_operation_e op);
    return (op == ALU_LSL) || (op == ALU_LSR) || (op == ALU_ASR);
  endfunction

  function automatic alu_flags_t mk_flags(logic z, logic n, logic c, logic v);
    alu_flags_t f;
    f.z = z;
    f.n = n;
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu                                                    |
// | Description : Single-cycle ALU datapath (ADD/OR/AND/XOR/NOT/NEG)     |
// |               with status flags. Iterative ops return zero here.     |
// | Revision    : 1.0 - initial sequential ALU release                   |
// +----------------------------------------------------------------------+
module alu
  import alu_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  alu_operation_e   op,
  output logic [Width-1:0] result,
  output alu_flags_t       flags
);

  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

  logic [Width:0]   w_sum;
  logic [Width-1:0] w_neg;
  logic             w_c;
  logic             w_v;
  logic             w_known;

  // Result and flag generation for the single-cycle operations.
  always_comb begin
    w_sum   = {1'b0, a} + {1'b0, b};
    w_neg   = '0 - a;
    result  = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_known = 1'b1;
    case (op)
      ALU_ADD: begin
        result = w_sum[Width-1:0];
        w_c    = w_sum[Width];
        w_v    = (a[Width-1] == b[Width-1]) && (w_sum[Width-1] != a[Width-1]);
      end
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_NEG: begin
        result = w_neg;
        w_c    = (a != '0);
        w_v    = (a == MinNeg);
      end
      // Shifts, MUL and unknown encodings: zero result, all flags clear.
      default: w_known = 1'b0;
    endcase
    flags = mk_flags(w_known && (result == '0), w_known && result[Width-1], w_c, w_v);
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_seq                                                |
// | Description : Sequential ALU with valid/ready handshakes, registered |
// |               result/flags, bit-serial shifts and shift-add multiply.|
// | Revision    : 1.0 - initial sequential ALU release                   |
// +----------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_a,
  input  logic [Width-1:0] in_b,
  input  alu_operation_e   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_result,
  output alu_flags_t       out_flags
);

  localparam int AmtWidth = $clog2(Width) + 1;

  alu_seq_state_e   state_q, state_d;
  alu_operation_e   op_q, op_d;
  logic [Width-1:0] mcand_q, mcand_d;   // MUL multiplicand
  logic [Width-1:0] hi_q, hi_d;         // MUL upper partial product
  logic [Width-1:0] lo_q, lo_d;         // shift value / MUL lower half
  logic [AmtWidth-1:0] cnt_q, cnt_d;
  logic [Width-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  logic [Width-1:0]    w_alu_result;
  alu_flags_t          w_alu_flags;
  logic [AmtWidth-1:0] w_amt;
  logic [Width-1:0]    w_shift_val;
  logic                w_shift_c;
  logic [Width:0]      w_mul_sum;
  logic [Width-1:0]    w_mul_hi;
  logic [Width-1:0]    w_mul_lo;
  logic [Width-1:0]    w_fin_res;
  logic                w_fin_c;
  logic                w_fin_v;

  // Single-cycle ops are evaluated straight from the inputs and captured
  // at acceptance.
  alu #(.Width(Width)) u_alu (
    .a      (in_a),
    .b      (in_b),
    .op     (in_op),
    .result (w_alu_result),
    .flags  (w_alu_flags)
  );

  // Shift amount saturates at Width: every larger amount gives the same result.
  always_comb begin
    if (in_b >= Width'(Width)) w_amt = AmtWidth'(Width);
    else                       w_amt = in_b[AmtWidth-1:0];
  end

  // One iteration step of the active shift or multiply, plus final flags.
  always_comb begin
    w_shift_val = lo_q;
    w_shift_c   = 1'b0;
    case (op_q)
      ALU_LSL: begin
        w_shift_val = {lo_q[Width-2:0], 1'b0};
        w_shift_c   = lo_q[Width-1];
      end
      ALU_LSR: begin
        w_shift_val = {1'b0, lo_q[Width-1:1]};
        w_shift_c   = lo_q[0];
      end
      ALU_ASR: begin
        w_shift_val = {lo_q[Width-1], lo_q[Width-1:1]};
        w_shift_c   = lo_q[0];
      end
      default: ;
    endcase
    // Right-shifting shift-add: multiplier bits leave lo_q from the bottom
    // while product bits enter from the top.
    w_mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    w_mul_hi  = w_mul_sum[Width:1];
    w_mul_lo  = {w_mul_sum[0], lo_q[Width-1:1]};
    if (op_q == ALU_MUL) begin
      w_fin_res = w_mul_lo;
      w_fin_c   = (w_mul_hi != '0);
      w_fin_v   = w_fin_c;
    end else begin
      w_fin_res = w_shift_val;
      w_fin_c   = w_shift_c;
      w_fin_v   = 1'b0;
    end
  end

  // Next-state and datapath control for IDLE/BUSY/DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          if (in_op == ALU_MUL) begin
            mcand_d = in_a;
            lo_d    = in_b;
            hi_d    = '0;
            cnt_d   = AmtWidth'(Width);
            state_d = BUSY;
          end else if (is_shift(in_op)) begin
            lo_d  = in_a;
            cnt_d = w_amt;
            if (w_amt == '0) begin
              // Zero-amount shift passes A through; nothing shifted out.
              result_d = in_a;
              flags_d  = mk_flags(in_a == '0, in_a[Width-1], 1'b0, 1'b0);
              state_d  = DONE;
            end else begin
              state_d = BUSY;
            end
          end else begin
            result_d = w_alu_result;
            flags_d  = w_alu_flags;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == ALU_MUL) begin
          hi_d = w_mul_hi;
          lo_d = w_mul_lo;
        end else begin
          lo_d = w_shift_val;
        end
        if (cnt_q == AmtWidth'(1)) begin
          result_d = w_fin_res;
          flags_d  = mk_flags(w_fin_res == '0, w_fin_res[Width-1], w_fin_c, w_fin_v);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= ALU_ADD;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_seq                                             |
// | Description : Directed self-checking bench for alu_seq (Width=8).    |
// | Revision    : 1.0 - initial sequential ALU release                   |
// +----------------------------------------------------------------------+
module tb_alu_seq;
  import alu_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     in_a;
  logic [7:0]     in_b;
  alu_operation_e in_op;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_result;
  alu_flags_t     out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.Width(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, and measure the
  // number of edges (acceptance edge included) until out_valid rises.
  task automatic issue(input string tag, input alu_operation_e op,
                       input logic [7:0] a, input logic [7:0] b,
                       input int exp_lat, input logic [7:0] exp_res,
                       input logic [3:0] exp_flags);
    int lat;
    check({tag, ".in_ready"}, {15'd0, in_ready}, 16'd1);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = b ^ 8'h5A;
    in_op    = ALU_ADD;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 16'(lat), 16'(exp_lat));
    check({tag, ".result"}, {8'd0, out_result}, {8'd0, exp_res});
    check({tag, ".flags"}, {12'd0, out_flags}, {12'd0, exp_flags});
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".idle_after"}, {14'd0, in_ready, out_valid}, 16'b10);
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] raw_op;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = ALU_ADD;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.out_valid", {15'd0, out_valid}, 16'd0);
    check("reset.out_result", {8'd0, out_result}, 16'd0);
    check("reset.out_flags", {12'd0, out_flags}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset.in_ready", {15'd0, in_ready}, 16'd1);

    // Flag order in the expected nibble: {z, n, c, v}.
    issue("add_ovf", ALU_ADD, 8'h7F, 8'h01, 1, 8'h80, 4'b0101); consume("add_ovf");
    issue("add_carry", ALU_ADD, 8'hFF, 8'h01, 1, 8'h00, 4'b1010); consume("add_carry");
    issue("lsl3", ALU_LSL, 8'h81, 8'd3, 4, 8'h08, 4'b0000); consume("lsl3");
    issue("asr_sat", ALU_ASR, 8'h80, 8'd20, 9, 8'hFF, 4'b0110); consume("asr_sat");
    issue("mul_big", ALU_MUL, 8'h10, 8'h11, 9, 8'h10, 4'b0011); consume("mul_big");
    issue("mul_small", ALU_MUL, 8'h03, 8'h05, 9, 8'h0F, 4'b0000); consume("mul_small");
    issue("lsr1", ALU_LSR, 8'h81, 8'd1, 2, 8'h40, 4'b0010); consume("lsr1");
    issue("lsl0", ALU_LSL, 8'h55, 8'd0, 1, 8'h55, 4'b0000); consume("lsl0");
    issue("lsl8", ALU_LSL, 8'h01, 8'd8, 9, 8'h00, 4'b1010); consume("lsl8");
    issue("lsr_sat", ALU_LSR, 8'hFF, 8'd9, 9, 8'h00, 4'b1010); consume("lsr_sat");
    issue("asr2", ALU_ASR, 8'hB4, 8'd2, 3, 8'hED, 4'b0100); consume("asr2");
    issue("neg_min", ALU_NEG, 8'h80, 8'h00, 1, 8'h80, 4'b0111); consume("neg_min");
    issue("neg_zero", ALU_NEG, 8'h00, 8'h33, 1, 8'h00, 4'b1000); consume("neg_zero");
    issue("neg_one", ALU_NEG, 8'h01, 8'h00, 1, 8'hFF, 4'b0110); consume("neg_one");
    issue("xor", ALU_XOR, 8'hF0, 8'hFF, 1, 8'h0F, 4'b0000); consume("xor");
    issue("and", ALU_AND, 8'hF0, 8'h0F, 1, 8'h00, 4'b1000); consume("and");
    issue("not", ALU_NOT, 8'h00, 8'h12, 1, 8'hFF, 4'b0100); consume("not");
    issue("or", ALU_OR, 8'h80, 8'h01, 1, 8'h81, 4'b0100); consume("or");
    raw_op = 4'hF;
    issue("unknown", alu_operation_e'(raw_op), 8'h00, 8'h00, 1, 8'h00, 4'b0000);
    consume("unknown");

    // Backpressure: result held in DONE, new requests ignored.
    issue("bp", ALU_ADD, 8'h12, 8'h34, 1, 8'h46, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = ALU_MUL;
      in_a     = 8'(i + 3);
      in_b     = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp.hold", {in_ready, out_valid, 2'b00, out_flags, out_result},
            {1'b0, 1'b1, 2'b00, 4'b0000, 8'h46});
    end
    consume("bp");

    // Asynchronous reset in the middle of a multiply.
    issue_mul_then_reset();

    issue("post_rst", ALU_ADD, 8'h01, 8'h02, 1, 8'h03, 4'b0000); consume("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic issue_mul_then_reset();
    check("rst_mid.in_ready", {15'd0, in_ready}, 16'd1);
    in_op    = ALU_MUL;
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid.busy", {14'd0, in_ready, out_valid}, 16'b00);
    rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_mid.out_result", {8'd0, out_result}, 16'd0);
    check("rst_mid.out_flags", {12'd0, out_flags}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.after", {14'd0, in_ready, out_valid}, 16'b10);
  endtask

endmodule
`default_nettype wire
